mem_arb: RTL and testbench

Single-port memory arbiter and access sequencer for the core. Shares one memory bus between the instruction-fetch path and the load/store path. The load/store path carries the control unit's `memrw`/`memword` decode. Each transaction follows a registered request/acknowledge protocol. The block checks alignment, guarantees fetch forward progress, and can optionally time out bus accesses.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_timer.sv | 29 ++
 rtl/mem_arb.sv | 152 +++++++++++++++
 tb/tb_mem_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, access size codes and alignment rule for mem_arb
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE_I = 2'd1,
      S_ISSUE_D = 2'd2,
      S_RESP    = 2'd3
   } arb_state_t;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   // The reserved size code always faults.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         MEM_B:   misaligned = 1'b0;
         MEM_H:   misaligned = addr[0];
         MEM_W:   misaligned = (addr != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - loadable down-counter with expire flag for the bus timeout
// Present only when MEMARB_TIMEOUT_EN is defined.
`ifdef MEMARB_TIMEOUT_EN
module arb_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (dec && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign expired = (cnt == '0);

endmodule
`endif

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter between the fetch and load/store paths
// MEMARB_TIMEOUT_EN adds an abort of the bus access after TIMEOUT cycles without mack.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int FAIRCNT = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifreq,
   input  logic [31:0] ifaddr,
   output logic [31:0] ifrdata,
   output logic        ifack,
   input  logic        dreq,
   input  logic        dwe,
   input  logic [1:0]  dsize,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   output logic [31:0] drdata,
   output logic        dack,
   output logic        err,
   output logic        mreq,
   output logic        mwe,
   output logic [1:0]  msize,
   output logic [31:0] maddr,
   output logic [31:0] mwdata,
   input  logic [31:0] mrdata,
   input  logic        mack,
   output logic        busy
);

   localparam int            FW       = (FAIRCNT < 1) ? 1 : $clog2(FAIRCNT + 1);
   localparam logic [FW-1:0] FAIR_MAX = FW'(FAIRCNT);

   arb_state_t    state;
   logic [FW-1:0] fair;
   logic          fetch_wins;
   logic          d_grant;
   logic          d_bad;
   logic          i_bad;
   logic          timed_out;

   // Data normally wins; a fetch starved for FAIRCNT data grants takes the bus.
   assign fetch_wins = ifreq && (fair == FAIR_MAX);
   assign d_grant    = dreq && !fetch_wins;
   assign d_bad      = misaligned(dsize, daddr[1:0]);
   assign i_bad      = (ifaddr[1:0] != 2'b00);

`ifdef MEMARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic in_issue;
   assign in_issue = (state == S_ISSUE_I) || (state == S_ISSUE_D);

   arb_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state == S_IDLE),
      .value   (TW'(TIMEOUT - 1)),
      .dec     (in_issue),
      .expired (timed_out)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign timed_out      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         fair    <= '0;
         ifrdata <= '0;
         drdata  <= '0;
         ifack   <= 1'b0;
         dack    <= 1'b0;
         err     <= 1'b0;
         mreq    <= 1'b0;
         mwe     <= 1'b0;
         msize   <= MEM_B;
         maddr   <= '0;
         mwdata  <= '0;
         busy    <= 1'b0;
      end else begin
         ifack <= 1'b0;
         dack  <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (d_grant) begin
                  maddr  <= daddr;
                  mwe    <= dwe;
                  msize  <= dsize;
                  mwdata <= dwdata;
                  busy   <= 1'b1;
                  if (ifreq && (fair != FAIR_MAX))
                     fair <= fair + FW'(1);
                  if (d_bad) begin
                     state <= S_RESP;
                     dack  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state <= S_ISSUE_D;
                     mreq  <= 1'b1;
                  end
               end else if (ifreq) begin
                  maddr  <= ifaddr;
                  mwe    <= 1'b0;
                  msize  <= MEM_W;
                  mwdata <= '0;
                  busy   <= 1'b1;
                  fair   <= '0;
                  if (i_bad) begin
                     state <= S_RESP;
                     ifack <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state <= S_ISSUE_I;
                     mreq  <= 1'b1;
                  end
               end
            end
            S_ISSUE_I, S_ISSUE_D: begin
               if (mack) begin
                  mreq  <= 1'b0;
                  state <= S_RESP;
                  if (state == S_ISSUE_I) begin
                     ifrdata <= mrdata;
                     ifack   <= 1'b1;
                  end else begin
                     drdata <= mrdata;
                     dack   <= 1'b1;
                  end
               end else if (timed_out) begin
                  // Abandoned access: read data registers keep their old value.
                  mreq  <= 1'b0;
                  state <= S_RESP;
                  err   <= 1'b1;
                  ifack <= (state == S_ISSUE_I);
                  dack  <= (state == S_ISSUE_D);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb: directed cases plus a randomized transaction-level model
module tb_mem_arb;

   localparam int FAIRCNT = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifreq = 1'b0;
   logic [31:0] ifaddr = '0;
   logic [31:0] ifrdata;
   logic        ifack;
   logic        dreq = 1'b0;
   logic        dwe = 1'b0;
   logic [1:0]  dsize = 2'b00;
   logic [31:0] daddr = '0;
   logic [31:0] dwdata = '0;
   logic [31:0] drdata;
   logic        dack;
   logic        err;
   logic        mreq;
   logic        mwe;
   logic [1:0]  msize;
   logic [31:0] maddr;
   logic [31:0] mwdata;
   logic [31:0] mrdata = '0;
   logic        mack = 1'b0;
   logic        busy;

   mem_arb #(.FAIRCNT(FAIRCNT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .ifreq(ifreq), .ifaddr(ifaddr), .ifrdata(ifrdata), .ifack(ifack),
      .dreq(dreq), .dwe(dwe), .dsize(dsize), .daddr(daddr), .dwdata(dwdata),
      .drdata(drdata), .dack(dack), .err(err),
      .mreq(mreq), .mwe(mwe), .msize(msize), .maddr(maddr), .mwdata(mwdata),
      .mrdata(mrdata), .mack(mack), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Transaction-level reference: cycle numbers of the next IDLE, the mreq window and the ack.
   int          cyc, free_at, mreq_from, mreq_to, ack_at, fair;
   bit          txn_d, txn_err;
   logic [31:0] exp_addr, exp_wdata, last_i, last_d;
   logic        exp_we;
   logic [1:0]  exp_size;
   bit          i_on, d_on, i_done, d_done, cont_mode;
   int          n_acks;
   logic [9:0]  order;

   function automatic bit bad_data(input logic [1:0] sz, input logic [31:0] a);
      int nbytes;
      if (sz == 2'b11) return 1'b1;
      nbytes = 1 << sz;
      return (a % nbytes) != 0;
   endfunction

   task automatic new_fetch();
      logic [31:0] a;
      a = $urandom();
      if (cont_mode || ($urandom_range(0, 7) != 0)) a[1:0] = 2'b00;
      ifaddr = a;
   endtask

   task automatic new_data();
      logic [31:0] a;
      a = $urandom();
      if (cont_mode) begin
         dsize = 2'b10;
         dwe   = 1'b0;
         a[1:0] = 2'b00;
      end else begin
         dsize = 2'($urandom_range(0, 3));
         dwe   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      end
      daddr  = a;
      dwdata = $urandom();
   endtask

   task automatic tick();
      bit exp_mreq;
      int w;
      @(negedge clk);
      exp_mreq = (cyc >= mreq_from) && (cyc <= mreq_to);
      expect_eq("mreq", 32'(mreq), 32'(exp_mreq));
      expect_eq("busy", 32'(busy), 32'(cyc < free_at));
      expect_eq("ifack", 32'(ifack), 32'(cyc == ack_at && !txn_d));
      expect_eq("dack", 32'(dack), 32'(cyc == ack_at && txn_d));
      expect_eq("err", 32'(err), 32'(cyc == ack_at && txn_err));
      if (exp_mreq) begin
         expect_eq("maddr", maddr, exp_addr);
         expect_eq("msize", 32'(msize), 32'(exp_size));
         expect_eq("mwe", 32'(mwe), 32'(exp_we));
         if (txn_d && exp_we) expect_eq("mwdata", mwdata, exp_wdata);
      end
      if (cyc == ack_at) begin
         if (txn_d) expect_eq("drdata", drdata, last_d);
         else       expect_eq("ifrdata", ifrdata, last_i);
      end
      if (ifack || dack) begin
         if (n_acks < 10) order = {order[8:0], ifack};
         n_acks++;
      end

      if (i_done) begin
         i_done = 1'b0;
         i_on = cont_mode || ($urandom_range(0, 3) != 0);
         if (i_on) new_fetch();
      end else if (!i_on && ($urandom_range(0, 2) == 0)) begin
         i_on = 1'b1;
         new_fetch();
      end
      if (d_done) begin
         d_done = 1'b0;
         d_on = cont_mode || ($urandom_range(0, 3) != 0);
         if (d_on) new_data();
      end else if (!d_on && ($urandom_range(0, 2) == 0)) begin
         d_on = 1'b1;
         new_data();
      end
      ifreq = i_on;
      dreq  = d_on;

      mrdata = $urandom();
      if ((cyc == mreq_to) && (cyc >= mreq_from)) begin
         mack = 1'b1;
         if (txn_d) last_d = mrdata;
         else       last_i = mrdata;
      end else if ((cyc >= mreq_from) && (cyc < mreq_to)) begin
         mack = 1'b0;
      end else begin
         mack = !cont_mode && ($urandom_range(0, 3) == 0);
      end

      if (cyc == ack_at) begin
         if (txn_d) d_done = 1'b1;
         else       i_done = 1'b1;
      end
      if (cyc == free_at) begin
         if (dreq && !(ifreq && fair == FAIRCNT)) begin
            txn_d = 1'b1;
            if (ifreq && fair < FAIRCNT) fair++;
            exp_addr  = daddr;
            exp_we    = dwe;
            exp_size  = dsize;
            exp_wdata = dwdata;
            txn_err   = bad_data(dsize, daddr);
         end else if (ifreq) begin
            txn_d    = 1'b0;
            fair     = 0;
            exp_addr = ifaddr;
            exp_we   = 1'b0;
            exp_size = 2'b10;
            txn_err  = (ifaddr % 4) != 0;
         end
         if (dreq || ifreq) begin
            if (txn_err) begin
               mreq_from = cyc + 2;
               mreq_to   = cyc + 1;
               ack_at    = cyc + 1;
            end else begin
               w = cont_mode ? 0 : int'($urandom_range(0, 3));
               mreq_from = cyc + 1;
               mreq_to   = cyc + 1 + w;
               ack_at    = mreq_to + 1;
            end
            free_at = ack_at + 1;
         end else begin
            free_at = cyc + 1;
         end
      end
      cyc++;
   endtask

   task automatic fault_case(input string tag, input bit is_d, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] held);
      if (is_d) begin
         dreq = 1'b1; dwe = 1'b1; dsize = sz; daddr = a; dwdata = 32'h5555_aaaa;
      end else begin
         ifreq = 1'b1; ifaddr = a;
      end
      step();
      expect_eq({tag, "_ack"}, 32'(is_d ? dack : ifack), 32'd1);
      expect_eq({tag, "_err"}, 32'(err), 32'd1);
      expect_eq({tag, "_mreq"}, 32'(mreq), 32'd0);
      expect_eq({tag, "_hold"}, is_d ? drdata : ifrdata, held);
      dreq = 1'b0; ifreq = 1'b0;
      step();
      expect_eq({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      step(); step();
      expect_eq("rst_mreq", 32'(mreq), 32'd0);
      expect_eq("rst_busy", 32'(busy), 32'd0);
      expect_eq("rst_acks", 32'({ifack, dack, err}), 32'd0);
      expect_eq("rst_ifrdata", ifrdata, 32'd0);
      expect_eq("rst_drdata", drdata, 32'd0);
      expect_eq("rst_bus", {maddr[29:0], msize}, 32'd0);
      expect_eq("rst_mwdata", mwdata, 32'd0);
      expect_eq("rst_mwe", 32'(mwe), 32'd0);
      rst = 1'b0;

      // Word load at 0x100 with two wait states.
      dreq = 1'b1; dwe = 1'b0; dsize = 2'b10; daddr = 32'h100;
      step();
      expect_eq("ld_mreq1", 32'(mreq), 32'd1);
      expect_eq("ld_maddr", maddr, 32'h100);
      expect_eq("ld_msize", 32'(msize), 32'd2);
      step();
      expect_eq("ld_mreq2", 32'(mreq), 32'd1);
      step();
      expect_eq("ld_mreq3", 32'(mreq), 32'd1);
      expect_eq("ld_noack", 32'(dack), 32'd0);
      mack = 1'b1; mrdata = 32'hdeadbeef;
      step();
      expect_eq("ld_dack", 32'(dack), 32'd1);
      expect_eq("ld_drdata", drdata, 32'hdeadbeef);
      expect_eq("ld_err", 32'(err), 32'd0);
      expect_eq("ld_mreq4", 32'(mreq), 32'd0);
      mack = 1'b0; dreq = 1'b0;
      step();
      expect_eq("ld_idle", 32'(busy), 32'd0);

      fault_case("half103", 1'b1, 2'b01, 32'h103, 32'hdeadbeef);
      fault_case("size11", 1'b1, 2'b11, 32'h200, 32'hdeadbeef);
      fault_case("word102", 1'b1, 2'b10, 32'h102, 32'hdeadbeef);
      fault_case("fetch1002", 1'b0, 2'b10, 32'h1002, 32'h0);

      // Reset while the data access is on the bus.
      dreq = 1'b1; dwe = 1'b0; dsize = 2'b10; daddr = 32'h40;
      step();
      expect_eq("rmid_mreq_on", 32'(mreq), 32'd1);
      rst = 1'b1;
      step();
      expect_eq("rmid_mreq", 32'(mreq), 32'd0);
      expect_eq("rmid_busy", 32'(busy), 32'd0);
      expect_eq("rmid_dack", 32'(dack), 32'd0);
      rst = 1'b0; dreq = 1'b0;
      step();
      expect_eq("rmid_dack2", 32'(dack), 32'd0);
      ifreq = 1'b1; ifaddr = 32'h80;
      step();
      expect_eq("rmid_if_mreq", 32'(mreq), 32'd1);
      expect_eq("rmid_if_maddr", maddr, 32'h80);
      mack = 1'b1; mrdata = 32'h1234;
      step();
      expect_eq("rmid_ifack", 32'(ifack), 32'd1);
      expect_eq("rmid_ifrdata", ifrdata, 32'h1234);
      expect_eq("rmid_err", 32'({err, dack}), 32'd0);
      mack = 1'b0; ifreq = 1'b0;
      step();

      // Fetch with mack held low.
      ifreq = 1'b1; ifaddr = 32'h2000;
`ifdef MEMARB_TIMEOUT_EN
      begin
         int n;
         n = 0;
         step();
         while (mreq && n < 40) begin
            n++;
            step();
         end
         expect_eq("to_len", 32'(n), 32'(TIMEOUT));
         expect_eq("to_ifack", 32'(ifack), 32'd1);
         expect_eq("to_err", 32'(err), 32'd1);
         expect_eq("to_hold", ifrdata, 32'h1234);
         ifreq = 1'b0;
         step();
      end
`else
      repeat (300) step();
      expect_eq("stall_mreq", 32'(mreq), 32'd1);
      expect_eq("stall_ifack", 32'(ifack), 32'd0);
      mack = 1'b1; mrdata = 32'h5678;
      step();
      expect_eq("stall_ifack2", 32'(ifack), 32'd1);
      expect_eq("stall_err", 32'(err), 32'd0);
      expect_eq("stall_ifrdata", ifrdata, 32'h5678);
      mack = 1'b0; ifreq = 1'b0;
      step();
`endif

      // Model-checked phases start from a fresh reset.
      ifreq = 1'b0; dreq = 1'b0; mack = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0; free_at = 0; mreq_from = 1; mreq_to = 0; ack_at = -1; fair = 0;
      txn_d = 1'b0; txn_err = 1'b0; last_i = '0; last_d = '0;
      exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; exp_size = 2'b00;
      n_acks = 0; order = '0;

      // Both requesters continuously busy, zero-wait memory.
      cont_mode = 1'b1;
      i_on = 1'b1; d_on = 1'b1; i_done = 1'b0; d_done = 1'b0;
      new_fetch();
      new_data();
      repeat (40) tick();
      expect_eq("fair_acks", 32'(n_acks >= 10), 32'd1);
      expect_eq("fair_order", 32'(order), 32'b0000100001);

      cont_mode = 1'b0;
      repeat (3000) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
